// File: rtl/hilo_muldiv_ctrl.sv
// Iterative HI/LO multiply/divide sequencer for MULT, MULTU, DIV and DIVU.
// Operands are converted to magnitudes when the instruction is accepted.
// The unit runs WIDTH shift-add or restoring shift-subtract steps, then
// applies the sign fix while it registers HI/LO on entry to DONE.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | waiting; accepts start when flush is low (stall raised)
//   S_BUSY | one iteration step per cycle, WIDTH cycles, stall held high
//   S_DONE | result registered; one-cycle hilo_we unless flushed
module hilo_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             b_zero;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] acc_hi, acc_lo;

  logic             accept, last_step;
  logic             in_signed, in_a_neg, in_b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic [WIDTH-1:0] res_hi, res_lo;

  // Operand conditioning for the accept cycle: signed ops work on magnitudes.
  always_comb begin
    in_signed = ~op[0];
    in_a_neg  = in_signed & src_a[WIDTH-1];
    in_b_neg  = in_signed & src_b[WIDTH-1];
    abs_a     = in_a_neg ? (~src_a + 1'b1) : src_a;
    abs_b     = in_b_neg ? (~src_b + 1'b1) : src_b;
  end

  // One iteration step; the divide trial subtraction uses its top bit as borrow.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    if (is_div) begin
      if (!div_diff[WIDTH]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // Sign correction of the final step; divide-by-zero keeps all-ones / dividend.
  always_comb begin
    prod_fix = neg_q ? (~{step_hi, step_lo} + 1'b1) : {step_hi, step_lo};
    quo_fix  = (neg_q && !b_zero) ? (~step_lo + 1'b1) : step_lo;
    rem_fix  = neg_r ? (~step_hi + 1'b1) : step_hi;
    if (is_div) begin
      res_hi = rem_fix;
      res_lo = b_zero ? '1 : quo_fix;
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    busy      = 1'b0;
    hilo_we   = 1'b0;
    accept    = 1'b0;
    last_step = (cnt == CW'(WIDTH - 1));
    case (state)
      S_IDLE: begin
        accept = start & ~flush;
        stall  = accept;
        if (accept) state_nxt = S_BUSY;
      end
      S_BUSY: begin
        stall = 1'b1;
        busy  = 1'b1;
        if (flush)          state_nxt = S_IDLE;
        else if (last_step) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        hilo_we   = ~flush;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration accumulators and HI/LO result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi_out <= '0;
      lo_out <= '0;
    end else if (accept) begin
      cnt    <= '0;
      is_div <= op[1];
      neg_q  <= in_a_neg ^ in_b_neg;
      neg_r  <= in_a_neg;
      b_zero <= (src_b == '0);
      acc_hi <= '0;
      opnd   <= op[1] ? abs_b : abs_a;
      acc_lo <= op[1] ? abs_a : abs_b;
    end else if (state == S_BUSY && !flush) begin
      cnt    <= cnt + CW'(1);
      acc_hi <= step_hi;
      acc_lo <= step_lo;
      if (last_step) begin
        hi_out <= res_hi;
        lo_out <= res_lo;
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed corner cases, flush and
// reset paths, then random operations against an arithmetic reference model.
module tb_hilo_muldiv_ctrl;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a, src_b;
  logic             flush;
  logic             stall, busy, hilo_we;
  logic [WIDTH-1:0] hi_out, lo_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [WIDTH-1:0] prev_hi = '0;
  logic [WIDTH-1:0] prev_lo = '0;

  hilo_muldiv_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .flush(flush),
    .stall(stall), .busy(busy), .hilo_we(hilo_we),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference results from plain 64-bit arithmetic.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      2'b00: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin p = ua * ub; hi = p[63:32]; lo = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
        end else if (o == 2'b10) begin
          sq = sa / sb;
          sr = sa % sb;
          p  = sq; lo = p[31:0];
          p  = sr; hi = p[31:0];
        end else begin
          p  = ua / ub; lo = p[31:0];
          p  = ua % ub; hi = p[31:0];
        end
      end
    endcase
  endtask

  // Runs one instruction from the current negedge to the IDLE cycle after it.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int flush_busy, input bit flush_done, input bit hold,
                       input string tag);
    logic [31:0] eh, el;
    int nst, nwe;
    model(o, a, b, eh, el);
    op = o; src_a = a; src_b = b; start = 1'b1; flush = 1'b0;
    #1 chk({tag, " accept stall"}, stall, 1);
    nst = 1; nwe = 0;
    for (int k = 1; k <= WIDTH; k++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      src_a = $urandom; src_b = $urandom; op = 2'($urandom);
      flush = (k == flush_busy);
      #1;
      if (stall) nst++;
      if (hilo_we) nwe++;
      if (k == flush_busy) begin
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        #1;
        chk({tag, " flush busy"}, busy, 0);
        chk({tag, " flush stall"}, stall, 0);
        chk({tag, " flush we"}, hilo_we | (nwe != 0), 0);
        chk({tag, " flush hi kept"}, hi_out, prev_hi);
        chk({tag, " flush lo kept"}, lo_out, prev_lo);
        return;
      end
    end
    chk({tag, " stall cycles"}, nst, WIDTH + 1);
    chk({tag, " we in busy"}, nwe, 0);
    @(negedge clk);
    flush = flush_done;
    #1;
    chk({tag, " done we"}, hilo_we, !flush_done);
    chk({tag, " done stall"}, stall, 0);
    chk({tag, " done busy"}, busy, 1);
    chk({tag, " hi"}, hi_out, eh);
    chk({tag, " lo"}, lo_out, el);
    if (hilo_we) nwe++;
    prev_hi = eh; prev_lo = el;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    chk({tag, " idle busy"}, busy, 0);
    chk({tag, " idle we"}, hilo_we, 0);
    if (hold) chk({tag, " we pulses"}, nwe, 1);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int          sel;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0; flush = 1'b0;
    #12;
    chk("reset busy", busy, 0);
    chk("reset we", hilo_we, 0);
    chk("reset stall", stall, 0);
    chk("reset hi", hi_out, 0);
    chk("reset lo", lo_out, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, "multu max");
    chk("multu max hi const", prev_hi, 32'hFFFF_FFFE);
    chk("multu max lo const", prev_lo, 32'h0000_0001);
    do_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 0, 0, 0, "mult -3x5");
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, "mult min*min");
    do_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0, 0, "div -7/2");
    do_op(2'b11, 32'h0000_0007, 32'h0000_0002, 0, 0, 0, "divu 7/2");
    do_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 0, 0, 0, "div 7/-2");
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, "div ovf");
    do_op(2'b11, 32'h0000_0005, 32'h0000_0000, 0, 0, 0, "divu /0");
    do_op(2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 0, 0, 0, "div -5/0");
    chk("div -5/0 hi const", hi_out, 32'hFFFF_FFFB);
    chk("div -5/0 lo const", lo_out, 32'hFFFF_FFFF);

    do_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 10, 0, 0, "flush busy10");
    do_op(2'b01, 32'd3, 32'd4, 0, 0, 0, "multu 3x4");
    chk("multu 3x4 lo const", lo_out, 32'd12);
    do_op(2'b00, 32'hDEAD_BEEF, 32'h0000_1234, 0, 1, 0, "flush done");
    do_op(2'b11, 32'd100, 32'd7, 0, 0, 1, "start hold");

    // A flushed start in IDLE must not be accepted.
    start = 1'b1; flush = 1'b1; op = 2'b01; src_a = 32'd9; src_b = 32'd9;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1 chk("flush blocks accept", busy, 0);

    // Asynchronous reset in the middle of an operation.
    start = 1'b1; op = 2'b01; src_a = 32'hFFFF_0000; src_b = 32'h0000_FFFF;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst busy", busy, 0);
    chk("async rst we", hilo_we, 0);
    chk("async rst hi", hi_out, 0);
    chk("async rst lo", lo_out, 0);
    prev_hi = '0; prev_lo = '0;
    #3 rst_n = 1'b1;
    @(negedge clk);
    do_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 0, 0, 0, "after reset");

    for (int i = 0; i < 30; i++) begin
      ro  = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 32'd0;
      if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      if (sel == 2) rb = 32'($urandom_range(1, 15));
      do_op(ro, ra, rb, (sel == 4) ? $urandom_range(1, WIDTH) : 0, sel == 3, sel == 5,
            $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
Iterative multiply/divide sequencer that produces the HI/LO results for MULT, MULTU, DIV and DIVU. It sits in the EX stage beside the HI/LO forwarding logic. It stalls the pipeline while it iterates, then issues a single-cycle HI/LO write. The write enable it raises is the source that feeds the HI/LO forwarding and write-back path.

Parameters:
WIDTH, 32, operand width; also the iteration count for both multiply and divide.

Ports:
clk  input  1  pipeline clock.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  mul/div instruction valid in EX.
op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
src_a  input  WIDTH  multiplicand / dividend.
src_b  input  WIDTH  multiplier / divisor.
flush  input  1  cancel the operation in flight (branch or exception squash).
stall  output  1  hold IF/ID/EX.
busy  output  1  unit occupied (state is BUSY or DONE).
hilo_we  output  1  one-cycle HI/LO write strobe.
hi_out  output  WIDTH  HI result.
lo_out  output  WIDTH  LO result.

Behaviour:
- Reset (rst_n=0): asynchronous.
  - State goes to IDLE; counter goes to 0.
  - hi_out=0, lo_out=0, hilo_we=0, busy=0.
  - stall=0 whenever start=0.
- Reset may occur mid-operation. The partial result is discarded and no write is issued.
- States: IDLE, BUSY, DONE.
- IDLE:
  - start=1 and flush=0: latch op; latch operands as absolute values for signed ops; record result signs; clear counter; go to BUSY.
  - stall is driven combinationally high in this accept cycle.
  - flush=1 blocks acceptance.
- BUSY:
  - One shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
  - Exactly WIDTH cycles, counter 0..WIDTH-1; on the last step go to DONE.
  - stall=1 and busy=1 throughout.
  - start is ignored.
- DONE:
  - Lasts one cycle; then IDLE.
  - Sign correction is applied; hi_out/lo_out are registered on entry to DONE and hold until the next DONE.
  - hilo_we=1, busy=1, stall=0, so the instruction leaves EX at the end of this cycle.
  - start is ignored, because the same instruction is still present in EX.
- Latency: the instruction is stalled for WIDTH+1 cycles. hilo_we is asserted on cycle WIDTH+2, counting the accept cycle as 1.
- Multiply: {hi_out, lo_out} = full 2*WIDTH-bit product. MULT is a signed product; MULTU is unsigned.
- Divide: lo_out = quotient, hi_out = remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero (src_b=0), both DIV and DIVU: lo_out = all ones, hi_out = src_a unchanged. The sign-fix step must not alter this.
- Signed overflow (DIV of most-negative value by -1): lo_out = most-negative value, hi_out = 0.
- flush:
  - In BUSY: go to IDLE next cycle; no hilo_we; hi_out/lo_out keep their previous values.
  - In DONE: hilo_we is forced to 0 combinationally; result registers are still updated.
- Back-to-back instructions: the next start is accepted in the IDLE cycle immediately after DONE. There is no dead cycle beyond that.
- Operands are sampled only in the accept cycle. src_a/src_b may change freely afterwards.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> stall high exactly 33 consecutive cycles; next cycle hilo_we=1, hi_out=0xFFFFFFFE, lo_out=0x00000001, stall=0; returns to IDLE.
- MULT 0xFFFFFFFD (-3) x 0x00000005 -> hi_out=0xFFFFFFFF, lo_out=0xFFFFFFF1. Then MULT 0x80000000 x 0x80000000 -> hi_out=0x40000000, lo_out=0x00000000.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF. DIVU 7 / 2 -> lo_out=3, hi_out=1. DIV 7 / 0xFFFFFFFE -> lo_out=0xFFFFFFFD, hi_out=1.
- DIV 0x80000000 / 0xFFFFFFFF -> lo_out=0x80000000, hi_out=0. DIVU 5 / 0 -> lo_out=0xFFFFFFFF, hi_out=5. DIV 0xFFFFFFFB / 0 -> lo_out=0xFFFFFFFF, hi_out=0xFFFFFFFB.
- Flush paths:
  - flush pulsed in the 10th BUSY cycle -> busy=0 and stall=0 next cycle, hilo_we never asserted, hi_out/lo_out unchanged; an immediate new MULTU 3x4 completes with lo_out=12.
  - flush during DONE -> hilo_we stays 0.
- Reset and start-hold:
  - rst_n driven low asynchronously mid-BUSY (no clock edge) -> busy, hilo_we, hi_out and lo_out read 0 immediately; after release, the unit is IDLE and accepts start.
  - start held high through DONE -> exactly one hilo_we pulse per accepted start.
